// File: rtl/debug_out_pkg.sv
// debug_out_pkg: beat type codes, default end-of-line byte and arbiter state encoding.
package debug_out_pkg;
   localparam logic [1:0] BEAT_BYTE        = 2'd0;
   localparam logic [1:0] BEAT_MAT_ELEM    = 2'd1;
   localparam logic [1:0] BEAT_MAT_END_ROW = 2'd2;
   localparam logic [1:0] BEAT_MAT_END     = 2'd3;
   localparam logic [7:0] EOL_CHAR_DEF     = 8'h0A;
   typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;
endpackage

// File: rtl/debug_output_arbiter_if.sv
// debug_output_arbiter_if: per-core print request ports and the shared debug output pins.
interface debug_output_arbiter_if #(parameter int NUM_CORES = 4);
   localparam int IW = $clog2(NUM_CORES);
   logic [NUM_CORES-1:0]    req_valid;
   logic [2*NUM_CORES-1:0]  req_type;
   logic [16*NUM_CORES-1:0] req_data;
   logic [NUM_CORES-1:0]    req_ready;
   logic                    out_byte_en;
   logic [7:0]              out_byte;
   logic                    out_matrix_en;
   logic [15:0]             out_matrix;
   logic                    out_matrix_end_row;
   logic                    out_matrix_end;
   logic [IW-1:0]           out_core_id;
   modport master (
      output req_valid, req_type, req_data,
      input  req_ready, out_byte_en, out_byte, out_matrix_en, out_matrix,
             out_matrix_end_row, out_matrix_end, out_core_id
   );
   modport slave (
      input  req_valid, req_type, req_data,
      output req_ready, out_byte_en, out_byte, out_matrix_en, out_matrix,
             out_matrix_end_row, out_matrix_end, out_core_id
   );
endinterface

// File: rtl/debug_output_arbiter_picker.sv
// rr_priority_picker: first set request at or after start, wrapping around, as index and one-hot.
module rr_priority_picker #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);
   always_comb begin : pick
      int j;
      j = 0;
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         j = (int'(start) + i) % N;
         if (!any && req[j]) begin
            any = 1'b1;
            idx = IW'(j);
         end
      end
      onehot = any ? (N'(1) << idx) : '0;
   end
endmodule

// File: rtl/debug_output_arbiter.sv
// debug_output_arbiter: round-robin owner of the debug output channel, locked for a whole
// text line or matrix so messages from different cores never interleave.
module debug_output_arbiter
   import debug_out_pkg::*;
#(
   parameter int          NUM_CORES = 4,
   parameter int          TIMEOUT   = 256,
   parameter logic [7:0]  EOL_CHAR  = EOL_CHAR_DEF
) (
   input logic clk,
   input logic resetn,
   debug_output_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_CORES);
   localparam int TW = $clog2(TIMEOUT + 1);
   arb_state_t           state, state_nx;
   logic [IW-1:0]        grant, grant_nx, rr_ptr, rr_ptr_nx, pick_idx;
   logic [NUM_CORES-1:0] grant_oh, grant_oh_nx, pick_oh;
   logic                 pick_any, accept, eom;
   logic [TW-1:0]        tcnt, tcnt_nx;
   logic [1:0]           beat_type;
   logic [15:0]          beat_data;

   rr_priority_picker #(.N(NUM_CORES)) u_pick (
      .req(bus.req_valid), .start(rr_ptr), .onehot(pick_oh), .idx(pick_idx), .any(pick_any)
   );

   // Ready is gated by reset so no beat is consumed while reset is held.
   assign bus.req_ready = (resetn && state == ST_LOCKED) ? grant_oh : '0;
   assign beat_type = bus.req_type[2*grant +: 2];
   assign beat_data = bus.req_data[16*grant +: 16];
   assign accept = |(bus.req_valid & bus.req_ready);
   assign eom = (beat_type == BEAT_BYTE && beat_data[7:0] == EOL_CHAR) || beat_type == BEAT_MAT_END;

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      grant_oh_nx = grant_oh;
      rr_ptr_nx = rr_ptr;
      tcnt_nx = tcnt;
      if (state == ST_IDLE) begin
         if (pick_any) begin
            state_nx = ST_LOCKED;
            grant_nx = pick_idx;
            grant_oh_nx = pick_oh;
            tcnt_nx = '0;
         end
      end else if ((accept && eom) || (!accept && int'(tcnt) + 1 >= TIMEOUT)) begin
         state_nx = ST_IDLE;
         rr_ptr_nx = (int'(grant) == NUM_CORES - 1) ? '0 : grant + 1'b1;
         tcnt_nx = '0;
      end else begin
         tcnt_nx = accept ? '0 : tcnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= ST_IDLE;
         grant <= '0;
         grant_oh <= '0;
         rr_ptr <= '0;
         tcnt <= '0;
         bus.out_byte_en <= 1'b0;
         bus.out_byte <= '0;
         bus.out_matrix_en <= 1'b0;
         bus.out_matrix <= '0;
         bus.out_matrix_end_row <= 1'b0;
         bus.out_matrix_end <= 1'b0;
         bus.out_core_id <= '0;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         grant_oh <= grant_oh_nx;
         rr_ptr <= rr_ptr_nx;
         tcnt <= tcnt_nx;
         bus.out_byte_en <= accept && beat_type == BEAT_BYTE;
         bus.out_matrix_en <= accept && beat_type == BEAT_MAT_ELEM;
         bus.out_matrix_end_row <= accept && beat_type == BEAT_MAT_END_ROW;
         bus.out_matrix_end <= accept && beat_type == BEAT_MAT_END;
         if (accept) begin
            bus.out_byte <= beat_data[7:0];
            bus.out_matrix <= beat_data;
            bus.out_core_id <= grant;
         end
      end
   end
endmodule

// File: tb/tb_debug_output_arbiter.sv
// tb_debug_output_arbiter: directed scenarios plus random traffic against a cycle-level
// model of the arbitration rules kept as plain integers and per-core beat queues.
module tb_debug_output_arbiter;
   import debug_out_pkg::*;
   localparam int N = 4;
   localparam int TMO = 16;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   debug_output_arbiter_if #(.NUM_CORES(N)) bus();
   debug_output_arbiter #(.NUM_CORES(N), .TIMEOUT(TMO), .EOL_CHAR(8'h0A)) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   int checks = 0, errors = 0;
   logic [17:0] mem [N][DEPTH];
   int head [N], tail [N];
   bit en [N];
   int cyc = 0;
   bit m_locked = 0;
   int m_own = 0, m_ptr = 0, m_idle = 0;
   int obs_id [$], obs_t [$];
   logic [3:0] obs_p [$];
   logic [15:0] obs_d [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input int c, input logic [1:0] t, input logic [15:0] d);
      mem[c][tail[c] % DEPTH] = {t, d};
      tail[c]++;
   endtask

   task automatic push_text(input int c, input string s);
      foreach (s[i]) push(c, BEAT_BYTE, {8'h00, s[i]});
      push(c, BEAT_BYTE, 16'h000A);
   endtask

   // One clock: drive every core's head beat, check ready and advance the model, then
   // check the pulses produced by the beat the model says was accepted.
   task automatic step();
      logic [N-1:0] v, exp_rdy;
      logic [17:0] b;
      logic [3:0] p, exp_p;
      bit in_rst;
      int acc;
      v = '0;
      b = '0;
      for (int c = 0; c < N; c++) begin
         v[c] = en[c] && head[c] != tail[c];
         bus.req_type[2*c +: 2] = mem[c][head[c] % DEPTH][17:16];
         bus.req_data[16*c +: 16] = mem[c][head[c] % DEPTH][15:0];
      end
      bus.req_valid = v;
      #1;
      exp_rdy = (resetn && m_locked) ? (N'(1) << m_own) : '0;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      acc = -1;
      in_rst = !resetn;
      if (in_rst) begin
         m_locked = 0;
         m_ptr = 0;
         m_idle = 0;
      end else if (!m_locked) begin
         for (int i = 0; i < N; i++) begin
            automatic int c = (m_ptr + i) % N;
            if (!m_locked && v[c]) begin
               m_locked = 1;
               m_own = c;
               m_idle = 0;
            end
         end
      end else if (v[m_own]) begin
         acc = m_own;
         b = mem[acc][head[acc] % DEPTH];
         head[acc]++;
         m_idle = 0;
         if ((b[17:16] == BEAT_BYTE && b[7:0] == 8'h0A) || b[17:16] == BEAT_MAT_END) begin
            m_locked = 0;
            m_ptr = (m_own + 1) % N;
         end
      end else begin
         m_idle++;
         if (m_idle == TMO) begin
            m_locked = 0;
            m_ptr = (m_own + 1) % N;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      exp_p = (acc < 0) ? 4'b0000 : (4'b1000 >> b[17:16]);
      p = {bus.out_byte_en, bus.out_matrix_en, bus.out_matrix_end_row, bus.out_matrix_end};
      chk("pulses", 32'(p), 32'(exp_p));
      if (in_rst)
         chk("reset_outputs", 32'({bus.out_byte_en, bus.out_byte, bus.out_matrix_en, bus.out_matrix,
             bus.out_matrix_end_row, bus.out_matrix_end, bus.out_core_id}), 32'd0);
      if (acc >= 0) begin
         chk("core_id", 32'(bus.out_core_id), acc);
         chk("payload", b[17:16] == BEAT_BYTE ? 32'(bus.out_byte) : 32'(bus.out_matrix),
             b[17:16] == BEAT_BYTE ? 32'(b[7:0]) : 32'(b[15:0]));
      end
      if (|p) begin
         obs_id.push_back(int'(bus.out_core_id));
         obs_t.push_back(cyc);
         obs_p.push_back(p);
         obs_d.push_back(bus.out_byte_en ? {8'h00, bus.out_byte} : bus.out_matrix);
      end
   endtask

   task automatic clear_log();
      obs_id.delete();
      obs_t.delete();
      obs_p.delete();
      obs_d.delete();
   endtask

   task automatic rst();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      for (int c = 0; c < N; c++) begin
         head[c] = tail[c];
         en[c] = 1'b1;
      end
      clear_log();
   endtask

   task automatic exp_obs(input string tag, input int k, input int id, input logic [3:0] p,
                          input logic [15:0] d);
      if (k >= obs_id.size()) chk({tag, "_count"}, obs_id.size(), k + 1);
      else begin
         chk({tag, "_id"}, obs_id[k], id);
         chk({tag, "_type"}, 32'(obs_p[k]), 32'(p));
         if (p[3] | p[2]) chk({tag, "_data"}, 32'(obs_d[k]), 32'(d));
      end
   endtask

   task automatic push_mat(input int c, input int rows, input int cols, input bit rnd);
      for (int r = 0; r < rows; r++) begin
         for (int k = 0; k < cols; k++)
            push(c, BEAT_MAT_ELEM, rnd ? 16'($urandom) : 16'(5 + r*cols + k));
         push(c, BEAT_MAT_END_ROW, 16'h0);
      end
      push(c, BEAT_MAT_END, 16'h0);
   endtask

   initial begin
      int t0, left, budget;
      logic [7:0] ch;
      for (int c = 0; c < N; c++) en[c] = 1'b1;
      bus.req_valid = '0;
      bus.req_type = '0;
      bus.req_data = '0;
      rst();

      // 1: lone core1 line
      t0 = cyc;
      push_text(1, "hi");
      repeat (6) step();
      chk("t1_count", obs_id.size(), 3);
      exp_obs("t1_h", 0, 1, 4'b1000, 16'h0068);
      exp_obs("t1_i", 1, 1, 4'b1000, 16'h0069);
      exp_obs("t1_eol", 2, 1, 4'b1000, 16'h000A);
      if (obs_t.size() == 3) begin
         chk("t1_first_cycle", obs_t[0], t0 + 2);
         chk("t1_consecutive", obs_t[2] - obs_t[0], 2);
      end

      // 2: tie between cores 0 and 2, then a tie with the pointer at 1
      rst();
      push_text(0, "ab");
      push_text(2, "ab");
      repeat (10) step();
      for (int k = 0; k < 6; k++)
         exp_obs("t2_seq", k, k < 3 ? 0 : 2, 4'b1000, k % 3 == 0 ? 16'h61 : k % 3 == 1 ? 16'h62 : 16'h0A);
      rst();
      push(0, BEAT_BYTE, 16'h000A);
      repeat (4) step();
      clear_log();
      push_text(0, "ab");
      push_text(2, "ab");
      repeat (10) step();
      exp_obs("t2_ptr1", 0, 2, 4'b1000, 16'h61);
      exp_obs("t2_ptr1_next", 3, 0, 4'b1000, 16'h61);

      // 3: core3 matrix holds off core0
      rst();
      push_mat(3, 2, 2, 1'b0);
      step();
      push_text(0, "q");
      repeat (14) step();
      exp_obs("t3_e5", 0, 3, 4'b0100, 16'd5);
      exp_obs("t3_e6", 1, 3, 4'b0100, 16'd6);
      exp_obs("t3_row0", 2, 3, 4'b0010, 16'd0);
      exp_obs("t3_e7", 3, 3, 4'b0100, 16'd7);
      exp_obs("t3_e8", 4, 3, 4'b0100, 16'd8);
      exp_obs("t3_row1", 5, 3, 4'b0010, 16'd0);
      exp_obs("t3_end", 6, 3, 4'b0001, 16'd0);
      exp_obs("t3_core0", 7, 0, 4'b1000, 16'h71);

      // 4: core0 sends "x" and goes quiet; timeout hands over to core1
      rst();
      push(0, BEAT_BYTE, 16'h0078);
      push_text(1, "y");
      repeat (24) step();
      exp_obs("t4_x", 0, 0, 4'b1000, 16'h78);
      exp_obs("t4_y", 1, 1, 4'b1000, 16'h79);
      if (obs_t.size() >= 2) chk("t4_timeout_gap", obs_t[1] - obs_t[0], TMO + 2);

      // 5: reset mid-matrix
      rst();
      push_mat(3, 2, 2, 1'b0);
      repeat (4) step();
      rst();
      push_text(3, "m");
      push_text(0, "n");
      repeat (8) step();
      exp_obs("t5_after_reset", 0, 0, 4'b1000, 16'h6E);

      // 6: all cores always requesting one-character lines
      rst();
      for (int c = 0; c < N; c++) begin
         push(c, BEAT_BYTE, 16'h000A);
         push(c, BEAT_BYTE, 16'h000A);
      end
      repeat (20) step();
      for (int k = 0; k < 8; k++) exp_obs("t6_rotation", k, k % N, 4'b1000, 16'h0A);

      // random traffic with random valid drops
      rst();
      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < N; c++) en[c] = $urandom_range(0, 7) != 0;
         if ($urandom_range(0, 3) == 0) begin
            automatic int c = $urandom_range(0, N - 1);
            if (tail[c] - head[c] < DEPTH - 20) begin
               if ($urandom_range(0, 1) == 1) begin
                  for (int k = $urandom_range(0, 4); k > 0; k--) begin
                     ch = 8'($urandom_range(0, 255));
                     push(c, BEAT_BYTE, {8'($urandom), ch == 8'h0A ? 8'h41 : ch});
                  end
                  push(c, BEAT_BYTE, {8'($urandom), 8'h0A});
               end else push_mat(c, $urandom_range(1, 2), $urandom_range(1, 3), 1'b1);
            end
         end
         step();
      end
      for (int c = 0; c < N; c++) en[c] = 1'b1;
      budget = 0;
      left = 1;
      while (left != 0 && budget < 3000) begin
         step();
         budget++;
         left = 0;
         for (int c = 0; c < N; c++) left += tail[c] - head[c];
      end
      chk("drain_left", left, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
